fir_out_stage: RTL

Downstream stage of the 4-tap FIR; consumes the 36-bit unsigned accumulator output y_out and aligns it to the input strobe via a valid delay line. Rounds and saturates it to OUT_WIDTH bits and buffers results in a small first-word-fall-through FIFO. Presents them to the consumer over a valid/ready handshake, with sticky saturation/overflow flags and a delivered-sample counter.

---
 rtl/fir_out_stage.sv | 133 +++++++++++++
 1 files changed

// File: rtl/fir_out_stage.sv
// rtl/fir_out_stage.sv - FIR output stage: valid alignment, round/saturate, FWFT FIFO, sticky flags
module fir_out_stage #(
    parameter int IN_WIDTH   = 36,
    parameter int OUT_WIDTH  = 18,
    parameter int SHIFT      = 16,
    parameter int LATENCY    = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_data_vld,
    input  logic [IN_WIDTH-1:0]           y_in,
    input  logic                          clr_flags,
    output logic [OUT_WIDTH-1:0]          out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          sat_flag,
    output logic                          ovf_flag,
    output logic [15:0]                   sample_count,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam int RW = IN_WIDTH + 1 - SHIFT;
    localparam logic [IN_WIDTH:0] RND = (IN_WIDTH + 1)'(1) << (SHIFT - 1);

    logic [LATENCY-1:0]   vld_q, vld_d;
    logic                 cap_en;

    logic [IN_WIDTH:0]    rnd_sum;
    logic [RW-1:0]        rnd_shr;
    logic                 over;
    logic [OUT_WIDTH-1:0] result;

    logic [OUT_WIDTH-1:0] s_data_q, s_data_d;
    logic                 s_vld_q, s_vld_d;

    logic [OUT_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]        level_q, level_d;
    logic                 sat_q, sat_d;
    logic                 ovf_q, ovf_d;
    logic [15:0]          cnt_q, cnt_d;

    logic                 push, pop, full, wr_en, drop;

    generate
        if (LATENCY == 1) begin : g_lat1
            assign vld_d = in_data_vld;
        end else begin : g_latn
            assign vld_d = {vld_q[LATENCY-2:0], in_data_vld};
        end
    endgenerate

    assign cap_en = vld_q[LATENCY-1];

    // One extra bit on the sum keeps the rounding carry of an all-ones input.
    assign rnd_sum = {1'b0, y_in} + RND;
    assign rnd_shr = rnd_sum[IN_WIDTH:SHIFT];

    generate
        if (RW > OUT_WIDTH) begin : g_sat
            assign over   = |rnd_shr[RW-1:OUT_WIDTH];
            assign result = over ? '1 : rnd_shr[OUT_WIDTH-1:0];
        end else begin : g_nosat
            assign over   = 1'b0;
            assign result = OUT_WIDTH'(rnd_shr);
        end
    endgenerate

    assign out_valid = (level_q != '0);
    assign full      = (level_q == LW'(FIFO_DEPTH));
    assign pop       = out_valid & out_ready;
    assign push      = s_vld_q;
    // A full FIFO still accepts a write when the head leaves on the same edge.
    assign wr_en     = push & (~full | pop);
    assign drop      = push & full & ~pop;

    always_comb begin
        s_vld_d  = cap_en;
        s_data_d = cap_en ? result : s_data_q;
        wr_ptr_d = wr_en ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop   ? rd_ptr_q + PW'(1) : rd_ptr_q;
        level_d  = level_q;
        if (wr_en && !pop) begin
            level_d = level_q + LW'(1);
        end else if (!wr_en && pop) begin
            level_d = level_q - LW'(1);
        end
        cnt_d = pop ? cnt_q + 16'd1 : cnt_q;
        sat_d = (sat_q & ~clr_flags) | (cap_en & over);
        ovf_d = (ovf_q & ~clr_flags) | drop;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_q    <= '0;
            s_data_q <= '0;
            s_vld_q  <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            cnt_q    <= '0;
            sat_q    <= 1'b0;
            ovf_q    <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            vld_q    <= vld_d;
            s_data_q <= s_data_d;
            s_vld_q  <= s_vld_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            cnt_q    <= cnt_d;
            sat_q    <= sat_d;
            ovf_q    <= ovf_d;
            if (wr_en) begin
                mem_q[wr_ptr_q] <= s_data_q;
            end
        end
    end

    assign out_data     = mem_q[rd_ptr_q];
    assign level        = level_q;
    assign sample_count = cnt_q;
    assign sat_flag     = sat_q;
    assign ovf_flag     = ovf_q;

endmodule
